// File: rtl/qsub_pipe.sv
// rtl/qsub_pipe.sv - two-stage sign-magnitude fixed-point subtractor with handshake and saturation
module qsub_pipe #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [N-1:0] o_c,
   output logic         o_ovf,
   output logic         o_valid,
   input  logic         i_ready
);

   // Saturated magnitude: every integer and fraction bit set.
   localparam logic [N-2:0] SAT_MAG = {{(N-1-Q){1'b1}}, {Q{1'b1}}};

   logic         s1_valid;
   logic         s1_sa;
   logic         s1_sb;
   logic [N-2:0] s1_ma;
   logic [N-2:0] s1_mb;
   logic         s1_ge;

   logic         s1_adv;
   logic         s2_adv;

   logic [N-1:0] sum;
   logic [N-2:0] r_mag;
   logic         r_sign;
   logic         r_ovf;

   assign s2_adv  = !o_valid || i_ready;
   assign s1_adv  = !s1_valid || s2_adv;
   assign o_ready = s1_adv;

   assign sum = {1'b0, s1_ma} + {1'b0, s1_mb};

   always_comb begin
      r_mag  = '0;
      r_sign = 1'b0;
      r_ovf  = 1'b0;
      if (s1_sa == s1_sb) begin
         r_sign = s1_sa;
         if (sum[N-1]) begin
            r_mag = SAT_MAG;
            r_ovf = 1'b1;
         end else begin
            r_mag = sum[N-2:0];
         end
      end else if (s1_ge) begin
         r_mag  = s1_ma - s1_mb;
         r_sign = s1_sa;
      end else begin
         r_mag  = s1_mb - s1_ma;
         r_sign = s1_sb;
      end
      // A zero magnitude never carries a negative sign.
      if (r_mag == '0) begin
         r_sign = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         o_valid  <= 1'b0;
         o_c      <= '0;
         o_ovf    <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
               s1_sa <= i_a[N-1];
               s1_sb <= ~i_b[N-1];
               s1_ma <= i_a[N-2:0];
               s1_mb <= i_b[N-2:0];
               s1_ge <= (i_a[N-2:0] >= i_b[N-2:0]);
            end
         end
         if (s2_adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
               o_c   <= {r_sign, r_mag};
               o_ovf <= r_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_qsub_pipe.sv
// tb/tb_qsub_pipe.sv - directed vector bench for qsub_pipe (Q=23, N=32)
module tb_qsub_pipe;

   localparam int N = 32;
   localparam int Q = 23;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] o_c;
   logic         o_ovf;
   logic         o_valid;
   logic         i_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        ovf;
   } vec_t;

   vec_t tv[13];

   qsub_pipe #(.Q(Q), .N(N)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_a    (i_a),
      .i_b    (i_b),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_c    (o_c),
      .o_ovf  (o_ovf),
      .o_valid(o_valid),
      .i_ready(i_ready)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] prev_c;
      logic        prev_ovf;
      logic        prev_stall;
      logic        acc;
      logic        out;
      int          sent;
      int          got;
      int          first_block;
      int          last_out;
      int          cyc;

      tv[0]  = '{32'h0180_0000, 32'h0080_0000, 32'h0100_0000, 1'b0};
      tv[1]  = '{32'h0080_0000, 32'h0180_0000, 32'h8100_0000, 1'b0};
      tv[2]  = '{32'h2000_0000, 32'h8030_0000, 32'h2030_0000, 1'b0};
      tv[3]  = '{32'h8080_0000, 32'h8080_0000, 32'h0000_0000, 1'b0};
      tv[4]  = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tv[5]  = '{32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1};
      tv[6]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
      tv[7]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0};
      tv[8]  = '{32'h8180_0000, 32'h8080_0000, 32'h8100_0000, 1'b0};
      tv[9]  = '{32'h8080_0000, 32'h8180_0000, 32'h0100_0000, 1'b0};
      tv[10] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
      tv[11] = '{32'h4000_0000, 32'hC000_0000, 32'h7FFF_FFFF, 1'b1};
      tv[12] = '{32'h3FFF_FFFF, 32'hC000_0000, 32'h7FFF_FFFF, 1'b0};

      i_rst   = 1'b1;
      i_a     = '0;
      i_b     = '0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_c", o_c, 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Single transfers: latency of two edges and the result of each vector.
      for (int i = 0; i < 13; i++) begin
         @(negedge i_clk);
         i_a     = tv[i].a;
         i_b     = tv[i].b;
         i_valid = 1'b1;
         i_ready = 1'b1;
         @(posedge i_clk);
         #1;
         i_valid = 1'b0;
         chk($sformatf("v%0d_lat1", i), 32'(o_valid), 32'd0);
         @(posedge i_clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'd1);
         chk($sformatf("v%0d_c", i), o_c, tv[i].c);
         chk($sformatf("v%0d_ovf", i), 32'(o_ovf), 32'(tv[i].ovf));
      end

      // Six back-to-back inputs with downstream stalled for cycles 3..6.
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      sent        = 0;
      got         = 0;
      first_block = -1;
      last_out    = -1;
      prev_stall  = 1'b0;
      prev_c      = '0;
      prev_ovf    = 1'b0;
      for (cyc = 0; cyc < 40 && got < 6; cyc++) begin
         if (cyc > 0) @(negedge i_clk);
         i_valid = (sent < 6);
         i_a     = 32'(sent + 1) << 23;
         i_b     = 32'h0080_0000;
         i_ready = !(cyc >= 3 && cyc <= 6);
         #1;
         if (prev_stall) begin
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_c", o_c, prev_c);
            chk("stall_ovf", 32'(o_ovf), 32'(prev_ovf));
         end
         if (!o_ready && first_block < 0) first_block = cyc;
         acc = i_valid && o_ready;
         out = o_valid && i_ready;
         if (out) begin
            chk($sformatf("stream%0d_c", got), o_c, 32'(got) << 23);
            got++;
            last_out = cyc;
         end
         prev_stall = o_valid && !i_ready;
         prev_c     = o_c;
         prev_ovf   = o_ovf;
         @(posedge i_clk);
         if (acc) sent++;
      end
      chk("stream_count", 32'(got), 32'd6);
      chk("stream_block_cyc", 32'(first_block), 32'd3);
      chk("stream_last_cyc", 32'(last_out), 32'd11);

      // Reset with both stages full.
      @(negedge i_clk);
      i_a     = 32'h7FFF_FFFF;
      i_b     = 32'h8000_0001;
      i_valid = 1'b1;
      i_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("full_valid", 32'(o_valid), 32'd1);
      chk("full_ready", 32'(o_ready), 32'd0);
      chk("full_ovf", 32'(o_ovf), 32'd1);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_rst   = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      chk("mrst_valid", 32'(o_valid), 32'd0);
      chk("mrst_c", o_c, 32'd0);
      chk("mrst_ovf", 32'(o_ovf), 32'd0);
      chk("mrst_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      chk("mrst_s1_flushed", 32'(o_valid), 32'd0);
      @(negedge i_clk);
      i_a     = 32'h0080_0000;
      i_b     = 32'h0180_0000;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      chk("post_rst_lat1", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      #1;
      chk("post_rst_valid", 32'(o_valid), 32'd1);
      chk("post_rst_c", o_c, 32'h8100_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
